// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default width for the timer counter.
package timer_pkg;
  localparam int TIMER_WIDTH = 16;
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'd0;
  localparam state_t RUN     = 2'd1;
  localparam state_t HOLD    = 2'd2;
  localparam state_t EXPIRED = 2'd3;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides RUN time into count ticks, one every PRESCALE cycles.
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic run,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt;
  assign tick = run && cnt == PW'(PRESCALE - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/timer_counter.sv
// timer_counter: loadable countdown with pause, one-cycle complete pulse and trigger reload.
// Optional count prescaling is enabled by defining TIMER_COUNTER_PRESCALE_EN.
module timer_counter
  import timer_pkg::*;
#(
  parameter int WIDTH          = TIMER_WIDTH,
  parameter int DEFAULT_PERIOD = 10,
  parameter int PRESCALE       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             trigger,
  output logic             complete,
  output logic             busy,
  output logic [WIDTH-1:0] count
);
  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic             tick;
`ifdef TIMER_COUNTER_PRESCALE_EN
  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (load || (state == EXPIRED && trigger)),
    .run    (state == RUN && enable),
    .tick   (tick)
  );
`else
  // every clock is a tick; a zero prescale would never count
  assign tick = PRESCALE >= 1;
`endif
  assign busy = state == RUN || state == HOLD;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      period_q <= WIDTH'(DEFAULT_PERIOD);
      count    <= WIDTH'(DEFAULT_PERIOD);
      complete <= 1'b0;
    end else if (load) begin
      state    <= IDLE;
      period_q <= load_value;
      count    <= load_value;
      complete <= 1'b0;
    end else begin
      complete <= 1'b0;
      case (state)
        IDLE: if (enable && period_q != '0) state <= RUN;
        RUN:
          if (!enable) state <= HOLD;
          else if (tick && count == WIDTH'(1)) begin
            count    <= '0;
            complete <= 1'b1;
            state    <= EXPIRED;
          end else if (tick && count > WIDTH'(1)) count <= count - 1'b1;
        HOLD: if (enable) state <= RUN;
        default:
          if (trigger) begin
            count <= period_q;
            state <= enable ? RUN : IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed stimulus with a behavioural model compared every cycle.
module tb_timer_counter;
  localparam int PRESCALE = 4;
  logic        clk = 1'b0;
  logic        reset_n, enable, load, trigger, chk_en = 1'b0;
  logic [15:0] load_value;
  logic        complete, busy;
  logic [15:0] count;
  int checks = 0, failures = 0;

  timer_counter #(.WIDTH(16), .DEFAULT_PERIOD(10), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .load_value(load_value),
    .trigger(trigger), .complete(complete), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // model: active = started (running or paused), paused, expired awaiting trigger
  logic [15:0] m_period, m_count;
  logic        m_active, m_paused, m_expired, m_complete;
  int          m_pre;
  logic        m_tick;
`ifdef TIMER_COUNTER_PRESCALE_EN
  assign m_tick = m_pre == PRESCALE - 1;
`else
  assign m_tick = 1'b1;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_period <= 16'd10; m_count <= 16'd10; m_active <= 1'b0; m_paused <= 1'b0;
      m_expired <= 1'b0; m_complete <= 1'b0; m_pre <= 0;
    end else if (load) begin
      m_period <= load_value; m_count <= load_value; m_active <= 1'b0; m_paused <= 1'b0;
      m_expired <= 1'b0; m_complete <= 1'b0; m_pre <= 0;
    end else begin
      m_complete <= 1'b0;
      if (m_expired) begin
        if (trigger) begin
          m_count <= m_period; m_expired <= 1'b0; m_active <= enable; m_paused <= 1'b0; m_pre <= 0;
        end
      end else if (!m_active) m_active <= enable && m_period != 0;
      else if (m_paused) m_paused <= !enable;
      else if (!enable) m_paused <= 1'b1;
      else begin
        m_pre <= m_tick ? 0 : m_pre + 1;
        if (m_tick && m_count == 1) begin
          m_count <= 16'd0; m_complete <= 1'b1; m_expired <= 1'b1; m_active <= 1'b0;
        end else if (m_tick && m_count > 1) m_count <= m_count - 16'd1;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) begin
      cmp("model_count", 32'(count), 32'(m_count));
      cmp("model_complete", 32'(complete), 32'(m_complete));
      cmp("model_busy", 32'(busy), 32'(m_active));
    end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; trigger = 1'b0;
    #12 reset_n = 1'b1;
    chk_en = 1'b1;
    cmp("reset_count", 32'(count), 32'd10);
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_complete", 32'(complete), 32'd0);
    step();
`ifdef TIMER_COUNTER_PRESCALE_EN
    begin
      int n = 0;
      do_load(16'd2);
      enable = 1'b1;
      do begin
        step();
        n++;
      end while (!complete && n <= 40);
      cmp("prescale_edges", 32'(n), 32'd9);
      step(2);
    end
`else
    do_load(16'd3);
    cmp("p3_loaded", 32'(count), 32'd3);
    enable = 1'b1;
    step(); cmp("p3_e0_count", 32'(count), 32'd3); cmp("p3_e0_busy", 32'(busy), 32'd1);
    step(); cmp("p3_e1_count", 32'(count), 32'd2);
    step(); cmp("p3_e2_count", 32'(count), 32'd1); cmp("p3_e2_complete", 32'(complete), 32'd0);
    step(); cmp("p3_e3_count", 32'(count), 32'd0); cmp("p3_e3_complete", 32'(complete), 32'd1);
    step(); cmp("p3_pulse_end", 32'(complete), 32'd0);
    step(10);
    cmp("expired_count", 32'(count), 32'd0); cmp("expired_busy", 32'(busy), 32'd0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    cmp("reload_count", 32'(count), 32'd3); cmp("reload_busy", 32'(busy), 32'd1);
    step(3); cmp("reload_complete", 32'(complete), 32'd1);
    step();
    do_load(16'd5);
    cmp("p5_loaded", 32'(count), 32'd5); cmp("p5_loaded_busy", 32'(busy), 32'd0);
    step(3); cmp("p5_before_hold", 32'(count), 32'd3);
    enable = 1'b0;
    step(4); cmp("hold_count", 32'(count), 32'd3); cmp("hold_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    step(); cmp("resume_count", 32'(count), 32'd3);
    step(2); cmp("resume_count2", 32'(count), 32'd1);
    step(); cmp("resume_complete", 32'(complete), 32'd1);
    enable = 1'b0; trigger = 1'b1;
    step();
    trigger = 1'b0;
    cmp("reload_idle_count", 32'(count), 32'd5); cmp("reload_idle_busy", 32'(busy), 32'd0);
    do_load(16'd2);
    enable = 1'b1;
    step(2);
    enable = 1'b0;
    step(); cmp("drop_at1_count", 32'(count), 32'd1); cmp("drop_at1_complete", 32'(complete), 32'd0);
    enable = 1'b1;
    step(); cmp("drop_resume_count", 32'(count), 32'd1);
    step(); cmp("drop_resume_complete", 32'(complete), 32'd1);
    do_load(16'd0);
    step(20);
    cmp("zero_count", 32'(count), 32'd0); cmp("zero_busy", 32'(busy), 32'd0);
    do_load(16'd9);
    step(2); cmp("run9_count", 32'(count), 32'd8);
    do_load(16'd7);
    enable = 1'b0;
    cmp("load_in_run_count", 32'(count), 32'd7); cmp("load_in_run_busy", 32'(busy), 32'd0);
    do_load(16'd1);
    enable = 1'b1;
    step(2); cmp("p1_complete", 32'(complete), 32'd1);
    reset_n = 1'b0;
    #1;
    cmp("async_count", 32'(count), 32'd10);
    cmp("async_complete", 32'(complete), 32'd0);
    cmp("async_busy", 32'(busy), 32'd0);
    #1 reset_n = 1'b1;
    enable = 1'b0;
    step(2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
